// File: rtl/kanagawa_elastic_pkg.sv
// Shared types and helpers for the elastic flip-flop chain.
// Also holds the occupancy-width rule used by the top level.
package kanagawa_elastic_pkg;

    typedef enum logic {
        CHAIN_RIGID    = 1'b0,
        CHAIN_COLLAPSE = 1'b1
    } chain_mode_t;

    // Occupancy counts 0..depth, and never narrower than one bit.
    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/kanagawa_elastic_flip_flop_chain_if.sv
// One valid/ready/data channel. The master drives valid and data, and the slave drives ready.
// A beat transfers on a clock edge where valid && ready; the master holds data stable while valid && !ready.
interface kanagawa_elastic_flip_flop_chain_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/kanagawa_elastic_stage.sv
// One chain stage: a valid bit plus a data word, with load and a clear that wins over load.
// The data word is written only for valid beats, and is cleared only when RESET_DATA is set.
module kanagawa_elastic_stage
    import kanagawa_elastic_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit RESET_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             load,
    input  logic             clr,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge clk) begin
        if (clr) begin
            v <= 1'b0;
        end else if (load) begin
            v <= v_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clr && RESET_DATA) begin
            d <= '0;
        end else if (load && v_in) begin
            d <= d_in;
        end
    end

endmodule

// File: rtl/kanagawa_elastic_flip_flop_chain.sv
// DEPTH-stage elastic register chain with valid/ready on both ends.
// Supports bubble collapsing or rigid shifting, synchronous flush, and a registered occupancy count.
module kanagawa_elastic_flip_flop_chain
    import kanagawa_elastic_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          DEPTH      = 4,
    parameter chain_mode_t COLLAPSE   = CHAIN_COLLAPSE,
    parameter bit          RESET_DATA = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    kanagawa_elastic_flip_flop_chain_if.slave  in_if,
    kanagawa_elastic_flip_flop_chain_if.master out_if,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OW = occ_width(DEPTH);

    generate
        if (DEPTH == 0) begin : g_pass
            assign out_if.valid = in_if.valid;
            assign out_if.data  = in_if.data;
            assign in_if.ready  = out_if.ready;
            assign occupancy    = '0;

            logic unused_pass;
            assign unused_pass = ^{clk, rst, flush};
        end else begin : g_chain
            logic [DEPTH-1:0] v;
            logic [WIDTH-1:0] d [DEPTH];
            logic [DEPTH-1:0] load;
            logic             clr;
            logic             in_ready;
            logic             in_xfer;
            logic             out_xfer;
            logic [OW-1:0]    occ_q;

            assign clr = rst || flush;

            if (COLLAPSE == CHAIN_COLLAPSE) begin : g_collapse
                // Stage i may load when downstream accepts or any stage from i to the output is empty.
                for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
                    assign load[i] = out_if.ready || !(&v[DEPTH-1:i]);
                end
            end else begin : g_rigid
                assign load = {DEPTH{out_if.ready || !v[DEPTH-1]}};
            end

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                if (i == 0) begin : g_first
                    kanagawa_elastic_stage #(
                        .WIDTH      (WIDTH),
                        .RESET_DATA (RESET_DATA)
                    ) u_stage (
                        .clk  (clk),
                        .load (load[i]),
                        .clr  (clr),
                        .v_in (in_if.valid),
                        .d_in (in_if.data),
                        .v    (v[i]),
                        .d    (d[i])
                    );
                end else begin : g_next
                    kanagawa_elastic_stage #(
                        .WIDTH      (WIDTH),
                        .RESET_DATA (RESET_DATA)
                    ) u_stage (
                        .clk  (clk),
                        .load (load[i]),
                        .clr  (clr),
                        .v_in (v[i-1]),
                        .d_in (d[i-1]),
                        .v    (v[i]),
                        .d    (d[i])
                    );
                end
            end

            assign in_ready     = load[0] && !clr;
            assign in_if.ready  = in_ready;
            assign out_if.valid = v[DEPTH-1];
            assign out_if.data  = d[DEPTH-1];

            // The output beat is not counted during flush or reset, because the consumer must ignore it.
            assign in_xfer  = in_if.valid && in_ready;
            assign out_xfer = v[DEPTH-1] && out_if.ready && !clr;

            always_ff @(posedge clk) begin
                if (clr) begin
                    occ_q <= '0;
                end else begin
                    occ_q <= occ_q + OW'(in_xfer) - OW'(out_xfer);
                end
            end

            assign occupancy = occ_q;
        end
    endgenerate

endmodule

// File: tb/tb_kanagawa_elastic_flip_flop_chain.sv
// Directed test of the elastic chain: collapse mode, rigid mode and DEPTH=0 passthrough.
// It checks latency, backpressure, bubble collapse, streaming, flush and reset.
module tb_kanagawa_elastic_flip_flop_chain;
    import kanagawa_elastic_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    logic [2:0] occ_a;
    logic [2:0] occ_r;
    logic [0:0] occ_p;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    kanagawa_elastic_flip_flop_chain_if #(.WIDTH(32)) a_in ();
    kanagawa_elastic_flip_flop_chain_if #(.WIDTH(32)) a_out ();
    kanagawa_elastic_flip_flop_chain_if #(.WIDTH(32)) r_in ();
    kanagawa_elastic_flip_flop_chain_if #(.WIDTH(32)) r_out ();
    kanagawa_elastic_flip_flop_chain_if #(.WIDTH(32)) p_in ();
    kanagawa_elastic_flip_flop_chain_if #(.WIDTH(32)) p_out ();

    kanagawa_elastic_flip_flop_chain #(
        .WIDTH(32), .DEPTH(4), .COLLAPSE(CHAIN_COLLAPSE), .RESET_DATA(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_if(a_in), .out_if(a_out), .occupancy(occ_a)
    );

    kanagawa_elastic_flip_flop_chain #(
        .WIDTH(32), .DEPTH(4), .COLLAPSE(CHAIN_RIGID), .RESET_DATA(1'b0)
    ) u_rigid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_if(r_in), .out_if(r_out), .occupancy(occ_r)
    );

    kanagawa_elastic_flip_flop_chain #(
        .WIDTH(32), .DEPTH(0), .COLLAPSE(CHAIN_COLLAPSE), .RESET_DATA(1'b0)
    ) u_pass (
        .clk(clk), .rst(rst), .flush(flush),
        .in_if(p_in), .out_if(p_out), .occupancy(occ_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [31:0] d);
        a_in.valid = v;
        a_in.data  = d;
        #1;
    endtask

    task automatic set_both(input logic v, input logic [31:0] d);
        a_in.valid = v;
        a_in.data  = d;
        r_in.valid = v;
        r_in.data  = d;
        #1;
    endtask

    initial begin
        int idx;
        int n_in;
        int n_out;

        rst = 1'b1;
        flush = 1'b0;
        a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
        r_in.valid = 1'b0; r_in.data = '0; r_out.ready = 1'b0;
        p_in.valid = 1'b0; p_in.data = '0; p_out.ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", a_out.valid, 0);
        check("rst_occ", occ_a, 0);
        check("rst_in_ready", a_in.ready, 0);
        check("rst_out_data", a_out.data, 0);
        check("rst_rigid_valid", r_out.valid, 0);
        rst = 1'b0;

        // Latency of DEPTH with out_ready held high.
        a_out.ready = 1'b1;
        set_a(1, 32'h10);
        check("t1_in_ready", a_in.ready, 1);
        tick();
        set_a(1, 32'h11); tick();
        set_a(1, 32'h12); tick();
        set_a(0, 0);
        check("t1_c3_valid", a_out.valid, 0);
        check("t1_peak_occ", occ_a, 3);
        tick();
        check("t1_c4_valid", a_out.valid, 1);
        check("t1_c4_data", a_out.data, 32'h10);
        check("t1_c4_occ", occ_a, 3);
        tick();
        check("t1_c5_data", a_out.data, 32'h11);
        tick();
        check("t1_c6_data", a_out.data, 32'h12);
        check("t1_c6_occ", occ_a, 1);
        tick();
        check("t1_c7_valid", a_out.valid, 0);
        check("t1_c7_occ", occ_a, 0);

        // Backpressure: capacity is exactly DEPTH.
        a_out.ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            set_a(1, 32'h30 + idx);
            check($sformatf("t2_in_ready_%0d", k), a_in.ready, (k < 4) ? 1 : 0);
            if (k < 4) idx++;
            tick();
        end
        check("t2_full_in_ready", a_in.ready, 0);
        check("t2_full_occ", occ_a, 4);
        check("t2_head_data", a_out.data, 32'h30);
        tick();
        tick();
        set_a(0, 0);
        a_out.ready = 1'b1;
        #1;
        check("t2_release_in_ready", a_in.ready, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_drain_valid_%0d", k), a_out.valid, 1);
            check($sformatf("t2_drain_data_%0d", k), a_out.data, 32'h30 + k);
            tick();
        end
        check("t2_empty_valid", a_out.valid, 0);
        check("t2_empty_occ", occ_a, 0);

        // Bubble collapse against the rigid chain.
        a_out.ready = 1'b0;
        r_out.ready = 1'b0;
        set_both(1, 32'hA1); tick();
        set_both(0, 0); tick(); tick();
        set_both(1, 32'hB2);
        check("t3_in_ready", a_in.ready, 1);
        check("t3_rigid_in_ready", r_in.ready, 1);
        tick();
        set_both(0, 0);
        check("t3_rigid_stall", r_in.ready, 0);
        check("t3_rigid_occ", occ_r, 2);
        tick(); tick();
        check("t3_occ", occ_a, 2);
        check("t3_collapse_in_ready", a_in.ready, 1);
        check("t3_head_data", a_out.data, 32'hA1);
        check("t3_rigid_head_data", r_out.data, 32'hA1);
        a_out.ready = 1'b1;
        r_out.ready = 1'b1;
        #1;
        check("t3_out_a_valid", a_out.valid, 1);
        tick();
        check("t3_adjacent_valid", a_out.valid, 1);
        check("t3_adjacent_data", a_out.data, 32'hB2);
        check("t3_rigid_gap", r_out.valid, 0);
        tick();
        check("t3_empty_valid", a_out.valid, 0);
        check("t3_empty_occ", occ_a, 0);
        tick();
        check("t3_rigid_b_valid", r_out.valid, 1);
        check("t3_rigid_b_data", r_out.data, 32'hB2);
        tick();
        check("t3_rigid_empty", r_out.valid, 0);
        check("t3_rigid_occ_end", occ_r, 0);

        // A full chain streams at one beat per cycle.
        a_out.ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_a(1, 32'h20 + k);
            exp_q.push_back(32'h20 + k);
            tick();
        end
        check("t4_full_occ", occ_a, 4);
        a_out.ready = 1'b1;
        n_in = 0;
        n_out = 0;
        for (int k = 0; k < 8; k++) begin
            set_a(1, 32'h24 + k);
            check($sformatf("t4_in_ready_%0d", k), a_in.ready, 1);
            check($sformatf("t4_out_valid_%0d", k), a_out.valid, 1);
            check($sformatf("t4_out_data_%0d", k), a_out.data, exp_q.pop_front());
            check($sformatf("t4_occ_%0d", k), occ_a, 4);
            if (a_in.ready) n_in++;
            if (a_out.valid) n_out++;
            exp_q.push_back(32'h24 + k);
            tick();
        end
        check("t4_n_in", n_in, 8);
        check("t4_n_out", n_out, 8);
        set_a(0, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_drain_data_%0d", k), a_out.data, exp_q.pop_front());
            tick();
        end
        check("t4_drained_valid", a_out.valid, 0);

        // Flush discards in-flight words and refuses the input presented in the flush cycle.
        a_out.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_a(1, 32'h50 + k);
            tick();
        end
        check("t5_pre_flush_occ", occ_a, 3);
        flush = 1'b1;
        set_a(1, 32'h53);
        check("t5_flush_in_ready", a_in.ready, 0);
        tick();
        flush = 1'b0;
        set_a(0, 0);
        check("t5_post_flush_valid", a_out.valid, 0);
        check("t5_post_flush_occ", occ_a, 0);
        a_out.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t5_no_emit_%0d", k), a_out.valid, 0);
        end

        // Reset mid-stream also discards data and, with RESET_DATA set, zeros it.
        a_out.ready = 1'b0;
        set_a(1, 32'h60); tick();
        set_a(1, 32'h61); tick();
        set_a(0, 0); tick(); tick();
        check("t5_rst_pre_valid", a_out.valid, 1);
        check("t5_rst_pre_data", a_out.data, 32'h60);
        rst = 1'b1;
        set_a(1, 32'h62);
        check("t5_rst_in_ready", a_in.ready, 0);
        tick();
        check("t5_rst_valid", a_out.valid, 0);
        check("t5_rst_occ", occ_a, 0);
        check("t5_rst_data", a_out.data, 0);
        rst = 1'b0;
        set_a(0, 0);
        a_out.ready = 1'b1;
        tick();
        check("t5_after_rst_valid", a_out.valid, 0);
        check("t5_after_rst_occ", occ_a, 0);

        // DEPTH=0 is a pure passthrough.
        p_out.ready = 1'b1;
        p_in.valid = 1'b1;
        p_in.data = 32'hABCD;
        #1;
        check("t6_pass_valid", p_out.valid, 1);
        check("t6_pass_data", p_out.data, 32'hABCD);
        check("t6_pass_in_ready", p_in.ready, 1);
        check("t6_pass_occ", occ_p, 0);
        p_out.ready = 1'b0;
        #1;
        check("t6_pass_stall", p_in.ready, 0);
        p_in.valid = 1'b0;
        #1;
        check("t6_pass_idle", p_out.valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kanagawa_elastic_flip_flop_chain.md
Name: kanagawa_elastic_flip_flop_chain

Overview:
Parametrised DEPTH-stage register chain carrying WIDTH-bit data with a per-stage valid bit and a valid/ready handshake on both ends.
- Successor to the fixed-latency enable/clear chains: adds backpressure, optional bubble collapsing, synchronous flush and an occupancy count.
- Sits between a producer and a consumer that both use valid/ready, where a pipeline delay must tolerate stalls without dropping or duplicating data.

Parameters:
WIDTH, 32, data bits per stage.
DEPTH, 4, number of register stages; 0 gives a pure combinational passthrough.
COLLAPSE, 1, 1 = a bubble (empty stage) may be filled while downstream stalls; 0 = rigid mode, all stages shift together.
RESET_DATA, 0, 1 = data registers are also cleared by rst/flush; 0 = only the valid bits are cleared.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous discard of all stage contents
in_valid  in  1  producer data valid
in_ready  out  1  chain can accept this cycle
in_data  in  WIDTH  producer data
out_valid  out  1  output stage holds valid data
out_ready  in  1  consumer accepts this cycle
out_data  out  WIDTH  output stage data
occupancy  out  $clog2(DEPTH+1) (min 1)  number of valid stages

Behaviour:
- Stages are indexed 0 (input side) to DEPTH-1 (output side).
- out_valid = v[DEPTH-1] and out_data = d[DEPTH-1], both direct register outputs.
- Transfers: an input transfer is in_valid && in_ready; an output transfer is out_valid && out_ready.
- COLLAPSE=1:
  - rdy[DEPTH] = out_ready; rdy[i] = !v[i] || rdy[i+1]; in_ready = rdy[0].
  - When rdy[i] is high, stage i loads v/d from stage i-1 (stage 0 loads from in_valid/in_data). Otherwise it holds.
  - in_ready has a combinational path from out_ready through DEPTH gates. This is accepted.
- COLLAPSE=0:
  - en = out_ready || !v[DEPTH-1]. When en is high, every stage loads from its predecessor. in_ready = en.
- Data registers load only when the stage loads and the incoming valid is 1, to save power. Data in an invalid stage is don't-care unless RESET_DATA=1.
- Latency: with an empty chain and out_ready held high, data accepted in cycle t appears with out_valid in cycle t+DEPTH.
- Throughput: 1 transfer per cycle with out_ready held high.
- Capacity: DEPTH entries. When full and out_ready=0, in_ready=0.
- Simultaneous input and output transfer on a full chain is allowed; occupancy is unchanged.
- flush:
  - In the flush cycle, in_ready=0 and out_valid is still presented, but no transfer counts: the consumer must ignore out_valid while flush is high.
  - The cycle after flush, all v=0 and occupancy=0.
- rst has priority over flush. During rst and on the cycle after it: all v=0, out_valid=0, occupancy=0, and in_ready=0 while rst is high. Data is cleared only if RESET_DATA=1.
- Reset or flush mid-stream discards all in-flight data; nothing is emitted afterwards.
- occupancy is a registered count:
  - +1 on an input transfer, -1 on an output transfer, unchanged when both occur.
  - It must always equal popcount(v) and never exceed DEPTH.
- DEPTH=0: out_valid=in_valid, out_data=in_data, in_ready=out_ready, occupancy=0. flush and rst have no effect on the data path.
- Ordering is preserved. No entry is ever duplicated or lost except by flush or rst.

Decomposition:
- Package kanagawa_elastic_pkg holds:
  - function occ_width(depth) returning max(1, $clog2(depth+1));
  - enum chain_mode_t {CHAIN_RIGID=0, CHAIN_COLLAPSE=1}, used for the COLLAPSE parameter.
- One sub-module, kanagawa_elastic_stage: one valid+data register with load, clr and a RESET_DATA option, instantiated DEPTH times in a generate loop.
- The ready chain and the occupancy counter stay in the top level.

Test Plan:
1. DEPTH=4, COLLAPSE=1, out_ready=1; drive 0x10,0x11,0x12 back-to-back from cycle 0 -> out_valid with 0x10,0x11,0x12 in cycles 4,5,6; occupancy peaks at 3.
2. DEPTH=4, COLLAPSE=1, out_ready=0; push 5 words -> in_ready drops after 4 accepts; occupancy=4. Raise out_ready at cycle 10 -> words emerge in order, one per cycle.
3. Bubble collapse: DEPTH=4, out_ready=0, input word A then 2 idle cycles then word B -> both held, occupancy=2, B lands in stage 2 adjacent to A. With COLLAPSE=0, the same stimulus leaves in_ready=0 once A reaches stage 3.
4. Full chain with in_valid=1 and out_ready=1 for 8 cycles -> 8 in and 8 out, occupancy stays at 4, data order 0x20..0x27 intact.
5. flush asserted with occupancy=3 -> the next cycle shows out_valid=0 and occupancy=0, and the flush-cycle input is not accepted. rst asserted mid-stream does the same; with RESET_DATA=1, out_data=0.
6. DEPTH=0: in_data=0xABCD with in_valid=1 -> same-cycle out_data=0xABCD and out_valid=1; out_ready=0 -> in_ready=0.
